if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 29 ++
 rtl/if_stage_pc_next.sv | 25 ++
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes,
// FSM states, instruction field positions and the default reset PC.
package if_stage_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_REL  = 2'b01,
    PC_REG  = 2'b10,
    PC_RSVD = 2'b11
  } pc_src_e;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 21;
  localparam int unsigned COND_MSB   = 3;
  localparam int unsigned COND_LSB   = 0;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  // Relative and register branches count as taken; reserved behaves as sequential.
  function automatic logic is_taken(input logic [1:0] src);
    return (src == PC_REL) || (src == PC_REG);
  endfunction

endpackage

// File: rtl/if_stage_pc_next.sv
// Combinational next-PC selection for the fetch stage; the result is always
// word aligned and all arithmetic wraps modulo 2^64.
module if_stage_pc_next
  import if_stage_pkg::*;
(
  input  logic [63:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [63:0] branch_offset,
  input  logic [63:0] br_target,
  output logic [63:0] next_pc
);

  logic [63:0] target;

  always_comb begin
    target = pc + 64'd4;
    case (pc_src_e'(pc_src))
      PC_REL:  target = pc + (branch_offset << 2);
      PC_REG:  target = br_target;
      default: target = pc + 64'd4;
    endcase
    next_pc = target & ~64'h3;
  end

endmodule

// File: rtl/if_stage.sv
// Two-state (REQ/EXEC) instruction fetch stage with instruction register.
// Optional performance counters enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [63:0] branch_offset,
  input  logic [63:0] br_target,
  output logic [63:0] pc,
  output logic [31:0] instr,
  output logic [10:0] op_code,
  output logic [3:0]  cond,
  output logic        instr_valid,
  output logic [31:0] instr_count,
  output logic [31:0] taken_count
);

  state_e      state, state_nxt;
  logic        fetch_done;
  logic        commit;
  logic [63:0] next_pc;

  if_stage_pc_next u_pc_next (
    .pc            (pc),
    .pc_src        (pc_src),
    .branch_offset (branch_offset),
    .br_target     (br_target),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_REQ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_done  = 1'b0;
    commit      = 1'b0;
    case (state)
      ST_REQ: begin
        // Request is masked during reset even though the state already reads REQ.
        imem_req   = rst_n;
        fetch_done = imem_ack;
        if (imem_ack) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        instr_valid = ~stall;
        commit      = ~stall;
        if (!stall) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      if (fetch_done) instr <= imem_rdata;
      if (commit)     pc    <= next_pc;
    end
  end

  assign imem_addr = pc;
  assign op_code   = instr[OPCODE_MSB:OPCODE_LSB];
  assign cond      = instr[COND_MSB:COND_LSB];

`ifdef IF_STAGE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      taken_count <= '0;
    end else if (commit) begin
      instr_count <= instr_count + 32'd1;
      if (is_taken(pc_src)) taken_count <= taken_count + 32'd1;
    end
  end
`else
  assign instr_count = '0;
  assign taken_count = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed sequences, a next-PC vector table
// and a randomized run against a behavioural fetch/commit model.
module tb_if_stage;

  localparam logic [63:0] RPC = 64'h100;
`ifdef IF_STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  pc_src;
  logic [63:0] branch_offset;
  logic [63:0] br_target;
  logic [63:0] pc;
  logic [31:0] instr;
  logic [10:0] op_code;
  logic [3:0]  cond;
  logic        instr_valid;
  logic [31:0] instr_count;
  logic [31:0] taken_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] e_ic, e_tc;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_offset (branch_offset),
    .br_target     (br_target),
    .pc            (pc),
    .instr         (instr),
    .op_code       (op_code),
    .cond          (cond),
    .instr_valid   (instr_valid),
    .instr_count   (instr_count),
    .taken_count   (taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] start_pc;
    logic [1:0]  src;
    logic [63:0] off;
    logic [63:0] tgt;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_instr_count"}, 64'(instr_count), PERF ? 64'(e_ic) : 64'd0);
    check({tag, "_taken_count"}, 64'(taken_count), PERF ? 64'(e_tc) : 64'd0);
  endtask

  // Hold reset over two edges with a stale ack present, check, then release.
  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; pc_src = 2'b00;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    check("rst_pc", pc, RPC);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr_count", 64'(instr_count), 64'd0);
    check("rst_taken_count", 64'(taken_count), 64'd0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    e_ic = '0; e_tc = '0;
    #1;
    check("post_rst_imem_req", 64'(imem_req), 64'd1);
    check("post_rst_imem_addr", imem_addr, RPC);
  endtask

  // Entered in REQ; leaves the DUT in EXEC holding word.
  task automatic fetch(input logic [31:0] word, input int unsigned lat);
    imem_ack = 1'b0;
    for (int unsigned i = 0; i < lat; i++) tick();
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic commit(input logic [1:0] src, input logic [63:0] off, input logic [63:0] tgt);
    stall = 1'b0; pc_src = src; branch_offset = off; br_target = tgt;
    tick();
    e_ic++;
    if (src == 2'b01 || src == 2'b10) e_tc++;
    pc_src = 2'b00; branch_offset = '0; br_target = '0;
  endtask

  function automatic logic [63:0] ref_next(input logic [63:0] p, input logic [1:0] s,
                                           input logic [63:0] off, input logic [63:0] tgt);
    logic [63:0] t;
    if (s == 2'b01)      t = p + off * 64'd4;
    else if (s == 2'b10) t = tgt;
    else                 t = p + 64'd4;
    return t & ~64'd3;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0]        m_pc;
    logic [31:0]        m_instr;
    bit                 m_exec;
    logic [31:0]        m_ic, m_tc;
    int unsigned        lat;
    logic signed [63:0] so;

    vecs[0] = '{64'h100,                 2'b00, 64'h0,                 64'h0,                 64'h104};
    vecs[1] = '{64'h200,                 2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,               64'h1F0};
    vecs[2] = '{64'h400,                 2'b10, 64'h0,                 64'h3007,              64'h3004};
    vecs[3] = '{64'h200,                 2'b11, 64'h55,                64'h9999,              64'h204};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 2'b00, 64'h0,                 64'h0,                 64'h0};
    vecs[5] = '{64'h8,                   2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,               64'hFFFF_FFFF_FFFF_FFF8};
    vecs[6] = '{64'h100,                 2'b01, 64'h4000_0000_0000_0000, 64'h0,               64'h100};
    vecs[7] = '{64'h40,                  2'b10, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC};

    branch_offset = '0; br_target = '0; imem_rdata = '0;
    do_reset();

    // First fetch: ack one cycle late, then one-cycle commit window.
    imem_ack = 1'b0;
    tick();
    check("wait_imem_req", 64'(imem_req), 64'd1);
    check("wait_imem_addr", imem_addr, 64'h100);
    imem_ack = 1'b1; imem_rdata = 32'h8B02_0020;
    tick();
    imem_ack = 1'b0;
    check("first_instr", 64'(instr), 64'h8B02_0020);
    check("first_op_code", 64'(op_code), 64'h458);
    check("first_cond", 64'(cond), 64'h0);
    check("first_instr_valid", 64'(instr_valid), 64'd1);
    check("first_imem_req", 64'(imem_req), 64'd0);
    commit(2'b00, '0, '0);
    check("after_commit_valid", 64'(instr_valid), 64'd0);
    check("seq_imem_addr", imem_addr, 64'h104);
    check_cnt("first");

    // Walk sequentially to 0x200, then a relative branch of -4 words.
    for (int unsigned i = 0; i < 63; i++) begin
      fetch($urandom, 0);
      commit(2'b00, '0, '0);
    end
    check("walk_imem_addr", imem_addr, 64'h200);
    fetch(32'h1234_5678, 1);
    commit(2'b01, 64'hFFFF_FFFF_FFFF_FFFC, '0);
    check("rel_imem_addr", imem_addr, 64'h1F0);
    check("rel_taken_count", 64'(taken_count), PERF ? 64'd1 : 64'd0);
    check_cnt("rel");

    // Stall for three EXEC cycles with stale acks arriving.
    fetch(32'hF2A5_0C3B, 2);
    for (int unsigned i = 0; i < 3; i++) begin
      stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
      #1;
      check("stall_instr", 64'(instr), 64'hF2A5_0C3B);
      check("stall_pc", pc, 64'h1F0);
      check("stall_instr_valid", 64'(instr_valid), 64'd0);
      check("stall_imem_req", 64'(imem_req), 64'd0);
      tick();
    end
    imem_ack = 1'b0; stall = 1'b0;
    #1;
    check("release_instr_valid", 64'(instr_valid), 64'd1);
    check("release_instr", 64'(instr), 64'hF2A5_0C3B);
    commit(2'b00, '0, '0);
    check("release_instr_valid_after", 64'(instr_valid), 64'd0);
    check("release_imem_addr", imem_addr, 64'h1F4);
    check_cnt("release");

    // Next-PC vector table.
    for (int unsigned v = 0; v < 8; v++) begin
      fetch($urandom, 0);
      commit(2'b10, '0, vecs[v].start_pc);
      check($sformatf("vec%0d_start", v), imem_addr, vecs[v].start_pc);
      fetch($urandom, 1);
      commit(vecs[v].src, vecs[v].off, vecs[v].tgt);
      check($sformatf("vec%0d_imem_addr", v), imem_addr, vecs[v].exp_addr);
      check($sformatf("vec%0d_imem_req", v), 64'(imem_req), 64'd1);
      check_cnt($sformatf("vec%0d", v));
    end

    // Reset while a fetch is outstanding.
    fetch(32'hAAAA_5555, 0);
    commit(2'b10, '0, 64'h5000);
    check("pend_imem_addr", imem_addr, 64'h5000);
    imem_ack = 1'b0;
    tick();
    do_reset();
    tick();
    check("abandon_instr", 64'(instr), 64'd0);
    check("abandon_imem_addr", imem_addr, RPC);
    check("abandon_imem_req", 64'(imem_req), 64'd1);

    // Randomized run against the behavioural model.
    do_reset();
    m_pc = RPC; m_instr = '0; m_exec = 1'b0; m_ic = '0; m_tc = '0;
    lat = $urandom_range(0, 3);
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      if (!m_exec) begin
        if (lat == 0) begin imem_ack = 1'b1; imem_rdata = $urandom; end
        else begin imem_ack = 1'b0; lat--; end
      end else begin
        imem_ack = ($urandom_range(0, 3) == 0);
        imem_rdata = $urandom;
      end
      stall = ($urandom_range(0, 2) == 0);
      pc_src = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        so = 64'($urandom_range(0, 64));
        so = so - 64'sd32;
        branch_offset = so;
      end else begin
        branch_offset = {$urandom, $urandom};
      end
      br_target = {$urandom, $urandom};
      #1;
      check("rnd_imem_req", 64'(imem_req), m_exec ? 64'd0 : 64'd1);
      check("rnd_imem_addr", imem_addr, m_pc);
      check("rnd_pc", pc, m_pc);
      check("rnd_instr", 64'(instr), 64'(m_instr));
      check("rnd_op_code", 64'(op_code), 64'(m_instr >> 21));
      check("rnd_cond", 64'(cond), 64'(m_instr % 16));
      check("rnd_instr_valid", 64'(instr_valid), (m_exec && !stall) ? 64'd1 : 64'd0);
      check("rnd_instr_count", 64'(instr_count), PERF ? 64'(m_ic) : 64'd0);
      check("rnd_taken_count", 64'(taken_count), PERF ? 64'(m_tc) : 64'd0);
      if (!m_exec) begin
        if (imem_ack) begin m_instr = imem_rdata; m_exec = 1'b1; end
      end else if (!stall) begin
        m_pc = ref_next(m_pc, pc_src, branch_offset, br_target);
        m_exec = 1'b0;
        m_ic++;
        if (pc_src == 2'b01 || pc_src == 2'b10) m_tc++;
        lat = $urandom_range(0, 3);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
